// File: rtl/wave_seq_ctrl.sv
// -----------------------------------------------------------------------------
// wave_seq_ctrl
// Drives a wave generator through a programmable table of segments. Each
// segment has a wave type code and a dwell count. A run resets the generator,
// issues the segment's command, dwells, then advances. At the last segment it
// either wraps (loop) or finishes with a one-cycle done pulse.
//
// Ports
//   clk            system clock, rising edge
//   rst            synchronous active-high reset (clears table too)
//   cfg_we         table write strobe (honoured only while idle)
//   cfg_addr       table entry index
//   cfg_wave_type  wave type code for the entry
//   cfg_dwell      dwell count for the entry
//   last_seg       final segment index, captured on an accepted start
//   loop           repeat forever, captured on an accepted start
//   start          single-cycle run request
//   stop           abort request
//   busy           sequence running
//   done           one-cycle pulse at normal completion
//   cur_seg        active segment index
//   wg_rst         wave generator reset
//   wg_en          wave generator enable
//   wg_cmd_rdy     wave generator command-ready strobe
//   wg_wave_type   wave type code to the generator (held between commands)
// -----------------------------------------------------------------------------
module wave_seq_ctrl #(
  parameter int NUM_SEG = 4,
  parameter int DWELL_W = 16,
  localparam int SEG_W  = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [SEG_W-1:0]   cfg_addr,
  input  logic [7:0]         cfg_wave_type,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [SEG_W-1:0]   last_seg,
  input  logic               loop,
  input  logic               start,
  input  logic               stop,
  output logic               busy,
  output logic               done,
  output logic [SEG_W-1:0]   cur_seg,
  output logic               wg_rst,
  output logic               wg_en,
  output logic               wg_cmd_rdy,
  output logic [7:0]         wg_wave_type
);

  typedef enum logic [2:0] {
    IDLE,
    WG_RST,
    CMD,
    DWELL,
    NEXT
  } state_t;

  state_t state;
  state_t next_state;

  logic [7:0]         type_tbl  [NUM_SEG];
  logic [DWELL_W-1:0] dwell_tbl [NUM_SEG];

  logic [DWELL_W-1:0] dwell_cnt;
  logic [SEG_W-1:0]   last_q;
  logic               loop_q;
  logic               at_last;
  logic               seq_end;

  assign at_last = (cur_seg == last_q);
  assign seq_end = at_last && !loop_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. stop overrides every transition out of a running state.
  always_comb begin
    next_state = state;
    if (state != IDLE && stop) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (start && !stop) next_state = WG_RST;
        WG_RST:  next_state = CMD;
        CMD:     next_state = DWELL;
        DWELL:   if (dwell_cnt == '0) next_state = NEXT;
        NEXT:    next_state = seq_end ? IDLE : WG_RST;
        default: next_state = IDLE;
      endcase
    end
  end

  // Sequence table; writes are accepted only while idle so a run sees a
  // frozen table.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SEG; i++) begin
        type_tbl[i]  <= '0;
        dwell_tbl[i] <= '0;
      end
    end else if (cfg_we && state == IDLE) begin
      type_tbl[cfg_addr]  <= cfg_wave_type;
      dwell_tbl[cfg_addr] <= cfg_dwell;
    end
  end

  // Outputs are registered from next_state so each one is high in exactly the
  // cycle its state is occupied. done is decided on entry to NEXT, when
  // cur_seg still names the segment that just finished.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy         <= 1'b0;
      wg_en        <= 1'b0;
      wg_rst       <= 1'b0;
      wg_cmd_rdy   <= 1'b0;
      done         <= 1'b0;
      wg_wave_type <= '0;
      cur_seg      <= '0;
      last_q       <= '0;
      loop_q       <= 1'b0;
      dwell_cnt    <= '0;
    end else begin
      busy       <= (next_state != IDLE);
      wg_en      <= (next_state != IDLE);
      wg_rst     <= (next_state == WG_RST);
      wg_cmd_rdy <= (next_state == CMD);
      done       <= (next_state == NEXT) && seq_end;

      if (state == IDLE && next_state == WG_RST) begin
        cur_seg <= '0;
        last_q  <= last_seg;
        loop_q  <= loop;
      end else if (state == NEXT && next_state == WG_RST) begin
        cur_seg <= at_last ? '0 : cur_seg + SEG_W'(1);
      end

      if (next_state == CMD) begin
        wg_wave_type <= type_tbl[cur_seg];
      end

      // Counter holds dwell in the first DWELL cycle and counts down to zero,
      // giving dwell+1 DWELL cycles; it never decrements past zero.
      if (state == CMD) begin
        dwell_cnt <= dwell_tbl[cur_seg];
      end else if (state == DWELL && dwell_cnt != '0) begin
        dwell_cnt <= dwell_cnt - DWELL_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_wave_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wave_seq_ctrl
// Directed self-checking bench for wave_seq_ctrl. Cycle N of a run is the
// N-th cycle after the edge that accepted start; outputs are sampled 1 ns
// after each rising edge.
// -----------------------------------------------------------------------------
module tb_wave_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [7:0]  cfg_wave_type;
  logic [15:0] cfg_dwell;
  logic [1:0]  last_seg;
  logic        loop;
  logic        start;
  logic        stop;
  logic        busy;
  logic        done;
  logic [1:0]  cur_seg;
  logic        wg_rst;
  logic        wg_en;
  logic        wg_cmd_rdy;
  logic [7:0]  wg_wave_type;

  int checks;
  int errors;

  // Capture of command strobes and done pulses over a window of cycles.
  int         cap_n_cmd;
  int         cap_cmd_cyc  [16];
  logic [7:0] cap_cmd_type [16];
  logic [1:0] cap_cmd_seg  [16];
  int         cap_n_done;
  int         cap_done_cyc;

  wave_seq_ctrl #(
    .NUM_SEG (4),
    .DWELL_W (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_we        (cfg_we),
    .cfg_addr      (cfg_addr),
    .cfg_wave_type (cfg_wave_type),
    .cfg_dwell     (cfg_dwell),
    .last_seg      (last_seg),
    .loop          (loop),
    .start         (start),
    .stop          (stop),
    .busy          (busy),
    .done          (done),
    .cur_seg       (cur_seg),
    .wg_rst        (wg_rst),
    .wg_en         (wg_en),
    .wg_cmd_rdy    (wg_cmd_rdy),
    .wg_wave_type  (wg_wave_type)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input logic [1:0] addr, input logic [7:0] wtype,
                             input logic [15:0] dwell);
    cfg_we        = 1'b1;
    cfg_addr      = addr;
    cfg_wave_type = wtype;
    cfg_dwell     = dwell;
    tick();
    cfg_we        = 1'b0;
  endtask

  // Pulse start for one cycle; on return the bench sits in cycle 1 of the run.
  task automatic start_run(input logic [1:0] lseg, input logic lp);
    last_seg = lseg;
    loop     = lp;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic clear_capture();
    cap_n_cmd    = 0;
    cap_n_done   = 0;
    cap_done_cyc = -1;
  endtask

  // Sample cycles from_c..to_c; ends positioned in cycle to_c.
  task automatic capture(input int from_c, input int to_c);
    for (int c = from_c; c <= to_c; c++) begin
      if (wg_cmd_rdy === 1'b1 && cap_n_cmd < 16) begin
        cap_cmd_cyc[cap_n_cmd]  = c;
        cap_cmd_type[cap_n_cmd] = wg_wave_type;
        cap_cmd_seg[cap_n_cmd]  = cur_seg;
        cap_n_cmd++;
      end
      if (done === 1'b1) begin
        cap_n_done++;
        cap_done_cyc = c;
      end
      if (c < to_c) tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    checks++; if (wg_rst !== 1'b0) begin errors++; $display("[TB] FAIL reset_wg_rst: got %b expected 0", wg_rst); end
    checks++; if (wg_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_wg_en: got %b expected 0", wg_en); end
    checks++; if (wg_cmd_rdy !== 1'b0) begin errors++; $display("[TB] FAIL reset_cmd_rdy: got %b expected 0", wg_cmd_rdy); end
    checks++; if (wg_wave_type !== 8'd0) begin errors++; $display("[TB] FAIL reset_wave_type: got %0d expected 0", wg_wave_type); end
    checks++; if (cur_seg !== 2'd0) begin errors++; $display("[TB] FAIL reset_cur_seg: got %0d expected 0", cur_seg); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_start_with_stop();
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    checks++; if (busy !== 1'b0 || wg_rst !== 1'b0) begin errors++; $display("[TB] FAIL start_stop_idle: got busy=%b wg_rst=%b expected 0 0", busy, wg_rst); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL start_stop_idle2: got busy=%b expected 0", busy); end
  endtask

  task automatic test_single_segment();
    write_entry(2'd0, 8'd1, 16'd3);
    start_run(2'd0, 1'b0);
    checks++; if (wg_rst !== 1'b1 || busy !== 1'b1 || wg_en !== 1'b1 || wg_cmd_rdy !== 1'b0)
      begin errors++; $display("[TB] FAIL single_c1: got wg_rst=%b busy=%b wg_en=%b cmd=%b expected 1 1 1 0", wg_rst, busy, wg_en, wg_cmd_rdy); end
    checks++; if (cur_seg !== 2'd0) begin errors++; $display("[TB] FAIL single_c1_seg: got %0d expected 0", cur_seg); end
    tick();
    checks++; if (wg_cmd_rdy !== 1'b1 || wg_wave_type !== 8'd1 || wg_rst !== 1'b0)
      begin errors++; $display("[TB] FAIL single_c2_cmd: got cmd=%b type=%0d wg_rst=%b expected 1 1 0", wg_cmd_rdy, wg_wave_type, wg_rst); end
    for (int c = 3; c <= 6; c++) begin
      tick();
      checks++; if (busy !== 1'b1 || wg_cmd_rdy !== 1'b0 || wg_rst !== 1'b0 || done !== 1'b0)
        begin errors++; $display("[TB] FAIL single_dwell_c%0d: got busy=%b cmd=%b wg_rst=%b done=%b expected 1 0 0 0", c, busy, wg_cmd_rdy, wg_rst, done); end
    end
    tick();
    checks++; if (done !== 1'b1 || busy !== 1'b1)
      begin errors++; $display("[TB] FAIL single_c7_done: got done=%b busy=%b expected 1 1", done, busy); end
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b0 || wg_en !== 1'b0)
      begin errors++; $display("[TB] FAIL single_c8_idle: got busy=%b done=%b wg_en=%b expected 0 0 0", busy, done, wg_en); end
    checks++; if (wg_wave_type !== 8'd1) begin errors++; $display("[TB] FAIL single_type_hold: got %0d expected 1", wg_wave_type); end
  endtask

  task automatic test_three_segments();
    int         exp_cyc  [3];
    logic [7:0] exp_type [3];
    exp_cyc  = '{2, 16, 40};
    exp_type = '{8'd1, 8'd2, 8'd3};
    write_entry(2'd0, 8'd1, 16'd10);
    write_entry(2'd1, 8'd2, 16'd20);
    write_entry(2'd2, 8'd3, 16'd5);
    start_run(2'd2, 1'b0);
    clear_capture();
    capture(1, 48);
    checks++; if (cap_n_cmd !== 3) begin errors++; $display("[TB] FAIL three_cmd_count: got %0d expected 3", cap_n_cmd); end
    for (int i = 0; i < 3; i++) begin
      if (i < cap_n_cmd) begin
        checks++; if (cap_cmd_cyc[i] !== exp_cyc[i] || cap_cmd_type[i] !== exp_type[i] || cap_cmd_seg[i] !== 2'(i))
          begin errors++; $display("[TB] FAIL three_cmd%0d: got cycle=%0d type=%0d seg=%0d expected %0d %0d %0d", i, cap_cmd_cyc[i], cap_cmd_type[i], cap_cmd_seg[i], exp_cyc[i], exp_type[i], i); end
      end
    end
    checks++; if (cap_n_done !== 1 || cap_done_cyc !== 47)
      begin errors++; $display("[TB] FAIL three_done: got count=%0d cycle=%0d expected 1 47", cap_n_done, cap_done_cyc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL three_idle: got busy=%b expected 0", busy); end
  endtask

  task automatic test_loop_stop();
    int         exp_cyc  [4];
    logic [7:0] exp_type [4];
    exp_cyc  = '{2, 8, 14, 20};
    exp_type = '{8'd1, 8'd3, 8'd1, 8'd3};
    write_entry(2'd0, 8'd1, 16'd2);
    write_entry(2'd1, 8'd3, 16'd2);
    start_run(2'd1, 1'b1);
    clear_capture();
    capture(1, 22);
    checks++; if (cap_n_cmd !== 4) begin errors++; $display("[TB] FAIL loop_cmd_count: got %0d expected 4", cap_n_cmd); end
    for (int i = 0; i < 4; i++) begin
      if (i < cap_n_cmd) begin
        checks++; if (cap_cmd_cyc[i] !== exp_cyc[i] || cap_cmd_type[i] !== exp_type[i])
          begin errors++; $display("[TB] FAIL loop_cmd%0d: got cycle=%0d type=%0d expected %0d %0d", i, cap_cmd_cyc[i], cap_cmd_type[i], exp_cyc[i], exp_type[i]); end
      end
    end
    checks++; if (cap_n_done !== 0) begin errors++; $display("[TB] FAIL loop_no_done: got %0d expected 0", cap_n_done); end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++; if (busy !== 1'b0 || wg_en !== 1'b0 || done !== 1'b0 || wg_cmd_rdy !== 1'b0 || wg_rst !== 1'b0)
      begin errors++; $display("[TB] FAIL loop_stop: got busy=%b wg_en=%b done=%b cmd=%b wg_rst=%b expected 0 0 0 0 0", busy, wg_en, done, wg_cmd_rdy, wg_rst); end
    tick();
    clear_capture();
    capture(24, 28);
    checks++; if (cap_n_done !== 0 || cap_n_cmd !== 0 || busy !== 1'b0)
      begin errors++; $display("[TB] FAIL loop_after_stop: got done=%0d cmd=%0d busy=%b expected 0 0 0", cap_n_done, cap_n_cmd, busy); end
  endtask

  task automatic test_interference();
    // Table now: 0 {1,2}, 1 {3,2}, 2 {3,5}.
    start_run(2'd1, 1'b0);
    clear_capture();
    capture(1, 3);
    start         = 1'b1;
    cfg_we        = 1'b1;
    cfg_addr      = 2'd1;
    cfg_wave_type = 8'd2;
    cfg_dwell     = 16'd9;
    last_seg      = 2'd0;
    loop          = 1'b1;
    tick();
    cfg_addr      = 2'd0;
    capture(4, 4);
    start  = 1'b0;
    cfg_we = 1'b0;
    tick();
    capture(5, 20);
    checks++; if (cap_n_cmd !== 2) begin errors++; $display("[TB] FAIL intf_cmd_count: got %0d expected 2", cap_n_cmd); end
    if (cap_n_cmd >= 2) begin
      checks++; if (cap_cmd_cyc[0] !== 2 || cap_cmd_type[0] !== 8'd1)
        begin errors++; $display("[TB] FAIL intf_cmd0: got cycle=%0d type=%0d expected 2 1", cap_cmd_cyc[0], cap_cmd_type[0]); end
      checks++; if (cap_cmd_cyc[1] !== 8 || cap_cmd_type[1] !== 8'd3 || cap_cmd_seg[1] !== 2'd1)
        begin errors++; $display("[TB] FAIL intf_cmd1: got cycle=%0d type=%0d seg=%0d expected 8 3 1", cap_cmd_cyc[1], cap_cmd_type[1], cap_cmd_seg[1]); end
    end
    checks++; if (cap_n_done !== 1 || cap_done_cyc !== 12)
      begin errors++; $display("[TB] FAIL intf_done: got count=%0d cycle=%0d expected 1 12", cap_n_done, cap_done_cyc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL intf_no_restart: got busy=%b expected 0", busy); end

    write_entry(2'd0, 8'd2, 16'd9);
    start_run(2'd0, 1'b0);
    clear_capture();
    capture(1, 14);
    checks++; if (cap_n_cmd !== 1 || cap_cmd_cyc[0] !== 2 || cap_cmd_type[0] !== 8'd2)
      begin errors++; $display("[TB] FAIL intf_rerun_cmd: got count=%0d cycle=%0d type=%0d expected 1 2 2", cap_n_cmd, cap_cmd_cyc[0], cap_cmd_type[0]); end
    checks++; if (cap_n_done !== 1 || cap_done_cyc !== 13)
      begin errors++; $display("[TB] FAIL intf_rerun_done: got count=%0d cycle=%0d expected 1 13", cap_n_done, cap_done_cyc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL intf_rerun_idle: got busy=%b expected 0", busy); end
  endtask

  task automatic test_reset_mid_run();
    // Table now: 0 {2,9}, 1 {3,2}.
    start_run(2'd1, 1'b0);
    clear_capture();
    capture(1, 17);
    checks++; if (cap_n_cmd !== 2 || cap_cmd_cyc[1] !== 15 || cap_cmd_type[1] !== 8'd3 || cap_cmd_seg[1] !== 2'd1)
      begin errors++; $display("[TB] FAIL midrst_pre: got count=%0d cycle=%0d type=%0d seg=%0d expected 2 15 3 1", cap_n_cmd, cap_cmd_cyc[1], cap_cmd_type[1], cap_cmd_seg[1]); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (busy !== 1'b0 || wg_en !== 1'b0 || wg_rst !== 1'b0 || wg_cmd_rdy !== 1'b0 || done !== 1'b0)
      begin errors++; $display("[TB] FAIL midrst_ctrl: got busy=%b wg_en=%b wg_rst=%b cmd=%b done=%b expected 0 0 0 0 0", busy, wg_en, wg_rst, wg_cmd_rdy, done); end
    checks++; if (wg_wave_type !== 8'd0 || cur_seg !== 2'd0)
      begin errors++; $display("[TB] FAIL midrst_data: got type=%0d seg=%0d expected 0 0", wg_wave_type, cur_seg); end
    tick();
    start_run(2'd1, 1'b0);
    clear_capture();
    capture(1, 9);
    checks++; if (cap_n_cmd !== 2 || cap_cmd_cyc[0] !== 2 || cap_cmd_cyc[1] !== 6 || cap_cmd_type[0] !== 8'd0 || cap_cmd_type[1] !== 8'd0)
      begin errors++; $display("[TB] FAIL midrst_cleared_cmd: got count=%0d cycles=%0d,%0d types=%0d,%0d expected 2 2,6 0,0", cap_n_cmd, cap_cmd_cyc[0], cap_cmd_cyc[1], cap_cmd_type[0], cap_cmd_type[1]); end
    checks++; if (cap_n_done !== 1 || cap_done_cyc !== 8)
      begin errors++; $display("[TB] FAIL midrst_cleared_done: got count=%0d cycle=%0d expected 1 8", cap_n_done, cap_done_cyc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_idle: got busy=%b expected 0", busy); end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    cfg_we        = 1'b0;
    cfg_addr      = '0;
    cfg_wave_type = '0;
    cfg_dwell     = '0;
    last_seg      = '0;
    loop          = 1'b0;
    start         = 1'b0;
    stop          = 1'b0;
    clear_capture();
    $display("[TB] wave_seq_ctrl directed tests");
    test_reset();
    test_start_with_stop();
    test_single_segment();
    test_three_segments();
    test_loop_stop();
    test_interference();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
